nibble_serial_add_ctrl: RTL

Sequencing controller that performs a WIDTH-bit add or subtract by driving one shared 4-bit adder datapath ({cout,Sum}=A+B+cin) once per clock, least-significant nibble first, with the carry chained through a register. It sits between an operand producer and a result consumer, each using a valid/ready handshake. It trades latency for area in places where a full-width adder is not justified.

---
 rtl/nibble_serial_add_ctrl_if.sv | 39 +++
 rtl/nibble_serial_add_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl_if.sv
// rtl/nibble_serial_add_ctrl_if.sv - request/result handshake bundle for nibble_serial_add_ctrl (ovf present with ADD_OVF_EN)
interface nibble_serial_add_ctrl_if #(
    parameter int NIBBLES = 4
) ();
    localparam int WIDTH = 4 * NIBBLES;

    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             done_valid;
    logic             done_ready;
    logic             busy;
`ifdef ADD_OVF_EN
    logic             ovf;
`endif

    // Producer/consumer side of the controller
    modport master (
        output start_valid, a, b, cin, sub, done_ready,
        input  start_ready, sum, cout, done_valid, busy
`ifdef ADD_OVF_EN
        , input ovf
`endif
    );

    // Controller side
    modport slave (
        input  start_valid, a, b, cin, sub, done_ready,
        output start_ready, sum, cout, done_valid, busy
`ifdef ADD_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - serial nibble add/subtract controller, one 4-bit add per clock (optional ovf via ADD_OVF_EN)
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int WIDTH = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [4:0]       nib_sum;
`ifdef ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Shared 4-bit adder on the nibble selected by idx; shifting keeps the select width-clean
    always_comb begin
        a_sh    = a_q >> {idx_q, 2'b00};
        b_sh    = b_q >> {idx_q, 2'b00};
        nib_sum = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry_q};
    end

    // Next-state and datapath sequencing; sum/cout only move on entry to DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    // Subtract is A + ~B + 1, so cin is overridden
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                part_d[{idx_q, 2'b00} +: 4] = nib_sum[3:0];
                carry_d = nib_sum[4];
                if (idx_q == LAST_IDX) begin
                    sum_d   = part_d;
                    cout_d  = nib_sum[4];
`ifdef ADD_OVF_EN
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (part_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.done_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.done_valid  = (state_q == DONE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.sum         = sum_q;
    assign bus.cout        = cout_q;
`ifdef ADD_OVF_EN
    assign bus.ovf         = ovf_q;
`endif
endmodule
